// File: rtl/system.sv
// VGA 640x480 timing generator with a free-running heartbeat LED.
// A pixel divider produces a one-cycle pixel enable. The enable steps
// the horizontal counter, and the horizontal wrap steps the vertical
// counter. Both sync outputs are registered from the *next* counter
// value, so each sync changes on the same edge as the counter it decodes.
// Reset (btns) is asynchronous and active-high. Release takes effect on
// the first rising edge that sees btns low, with no synchronizer stage.
module system #(
   parameter int CLK_FREQ        = 100000000,
   parameter int LED_HALF_PERIOD = CLK_FREQ / 2,
   parameter int PIX_DIV         = 4,
   parameter int H_VISIBLE       = 640,
   parameter int H_FRONT         = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BACK          = 48,
   parameter int V_VISIBLE       = 480,
   parameter int V_FRONT         = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BACK          = 33
) (
   input  logic clk,
   input  logic btns,
   output logic Led,
   output logic Hsync,
   output logic Vsync
);

   // Derived timing constants, sized to the 10-bit counters.
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

   localparam int LED_W = (LED_HALF_PERIOD > 1) ? $clog2(LED_HALF_PERIOD) : 1;
   localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_HALF_PERIOD - 1);

   logic [DIV_W-1:0] div_q,   div_d;
   logic [9:0]       hcnt_q,  hcnt_d;
   logic [9:0]       vcnt_q,  vcnt_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic [LED_W-1:0] hb_q,    hb_d;
   logic             led_q,   led_d;

   logic pix_en;
   logic h_wrap;
   logic hb_wrap;

   // Video counter chain: the divider gates hcnt, and the hcnt wrap gates vcnt.
   always_comb begin
      pix_en = (div_q == DIV_LAST);
      h_wrap = pix_en && (hcnt_q == H_LAST);
      div_d  = pix_en ? '0 : div_q + DIV_W'(1);
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (pix_en) begin
         hcnt_d = h_wrap ? 10'd0 : hcnt_q + 10'd1;
      end
      if (h_wrap) begin
         vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end
   end

   // Sync decode from the next counter values, so each sync stays aligned with its counter.
   always_comb begin
      hsync_d = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
      vsync_d = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
   end

   // Heartbeat: toggle the LED each time the half-period counter wraps.
   always_comb begin
      hb_wrap = (hb_q == LED_LAST);
      hb_d    = hb_wrap ? '0 : hb_q + LED_W'(1);
      led_d   = hb_wrap ? ~led_q : led_q;
   end

   // State registers, cleared asynchronously by btns.
   always_ff @(posedge clk or posedge btns) begin
      if (btns) begin
         div_q   <= '0;
         hcnt_q  <= 10'd0;
         vcnt_q  <= 10'd0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         hb_q    <= '0;
         led_q   <= 1'b0;
      end else begin
         div_q   <= div_d;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         hb_q    <= hb_d;
         led_q   <= led_d;
      end
   end

   assign Hsync = hsync_q;
   assign Vsync = vsync_q;
   assign Led   = led_q;

endmodule

// File: tb/tb_system.sv
// Bench for system. Two instances share the clock and reset:
// - u0 uses the default parameters.
// - u1 uses a 100-cycle LED half period and a 10-line frame, so LED and
//   Vsync edges occur within a short run.
// The reference model computes each output from the count of edges
// since release.
module tb_system;

   logic clk  = 1'b0;
   logic btns = 1'b1;
   logic led0, hs0, vs0;
   logic led1, hs1, vs1;

   int checks   = 0;
   int failures = 0;
   int n;

   int hs0_fall[$];
   int hs0_rise[$];
   int led0_rise[$];
   int vs0_fall[$];
   int vs1_fall[$];
   int vs1_rise[$];
   int led1_rise[$];
   int led1_fall[$];
   logic p_hs0, p_vs0, p_led0, p_vs1, p_led1;

   system u0 (
      .clk   (clk),
      .btns  (btns),
      .Led   (led0),
      .Hsync (hs0),
      .Vsync (vs0)
   );

   system #(
      .LED_HALF_PERIOD (100),
      .V_VISIBLE       (4),
      .V_FRONT         (2),
      .V_SYNC          (2),
      .V_BACK          (2)
   ) u1 (
      .clk   (clk),
      .btns  (btns),
      .Led   (led1),
      .Hsync (hs1),
      .Vsync (vs1)
   );

   // Clock and the edges-since-release counter.
   always #5 clk = ~clk;

   always @(posedge clk or posedge btns) begin
      if (btns) n <= 0;
      else      n <= n + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int q_at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   // Model: after k edges the pixel index is k/PIX_DIV.
   // The line is that index divided by 800, and the position in line is the remainder.
   function automatic void model(input int k, input int vtot, input int vs_lo, input int vs_hi,
                                 input int lhp, output logic hs, output logic vs, output logic led);
      int pix, h, v;
      pix = k / 4;
      h   = pix % 800;
      v   = (pix / 800) % vtot;
      hs  = !(h >= 656 && h <= 751);
      vs  = !(v >= vs_lo && v <= vs_hi);
      led = ((k / lhp) % 2) == 1;
   endfunction

   // Per-cycle compare against the model, plus edge-time capture.
   always @(negedge clk) begin
      logic ehs0, evs0, eled0, ehs1, evs1, eled1;
      if (btns) begin
         ehs0 = 1'b1; evs0 = 1'b1; eled0 = 1'b0;
         ehs1 = 1'b1; evs1 = 1'b1; eled1 = 1'b0;
      end else begin
         model(n, 525, 490, 491, 50000000, ehs0, evs0, eled0);
         model(n, 10, 6, 7, 100, ehs1, evs1, eled1);
      end
      check("u0_hsync", int'(hs0), int'(ehs0));
      check("u0_vsync", int'(vs0), int'(evs0));
      check("u0_led",   int'(led0), int'(eled0));
      check("u1_hsync", int'(hs1), int'(ehs1));
      check("u1_vsync", int'(vs1), int'(evs1));
      check("u1_led",   int'(led1), int'(eled1));
      if (!btns) begin
         if (p_hs0 && !hs0)   hs0_fall.push_back(n);
         if (!p_hs0 && hs0)   hs0_rise.push_back(n);
         if (!p_led0 && led0) led0_rise.push_back(n);
         if (p_vs0 && !vs0)   vs0_fall.push_back(n);
         if (p_vs1 && !vs1)   vs1_fall.push_back(n);
         if (!p_vs1 && vs1)   vs1_rise.push_back(n);
         if (!p_led1 && led1) led1_rise.push_back(n);
         if (p_led1 && !led1) led1_fall.push_back(n);
      end
      p_hs0 = hs0; p_vs0 = vs0; p_led0 = led0; p_vs1 = vs1; p_led1 = led1;
   end

   task automatic clear_edges();
      hs0_fall.delete(); hs0_rise.delete(); led0_rise.delete(); vs0_fall.delete();
      vs1_fall.delete(); vs1_rise.delete(); led1_rise.delete(); led1_fall.delete();
   endtask

   // Stimulus sequence.
   initial begin
      int hold;
      bit found;
      p_hs0 = 1'b1; p_vs0 = 1'b1; p_led0 = 1'b0; p_vs1 = 1'b1; p_led1 = 1'b0;

      // Power-on reset for 80 ns, then release between edges.
      #80;
      check("rst_hsync", int'(hs0), 1);
      check("rst_vsync", int'(vs0), 1);
      check("rst_led",   int'(led0), 0);
      @(negedge clk);
      btns = 1'b0;
      clear_edges();
      #1;
      check("rel_hsync", int'(hs0), 1);
      check("rel_vsync", int'(vs0), 1);
      check("rel_led",   int'(led0), 0);

      repeat (55000) @(posedge clk);
      @(negedge clk);
      check("hs_fall0",  q_at(hs0_fall, 0), 2624);
      check("hs_rise0",  q_at(hs0_rise, 0), 3008);
      check("hs_fall1",  q_at(hs0_fall, 1), 5824);
      check("led_rise0", q_at(led1_rise, 0), 100);
      check("led_fall0", q_at(led1_fall, 0), 200);
      check("led_rise1", q_at(led1_rise, 1), 300);
      check("vs_fall0",  q_at(vs1_fall, 0), 19200);
      check("vs_rise0",  q_at(vs1_rise, 0), 25600);
      check("vs_fall1",  q_at(vs1_fall, 1), 51200);
      check("u0_led_quiet",   led0_rise.size(), 0);
      check("u0_vsync_quiet", vs0_fall.size(), 0);

      // Mid-line reset: wait for the Hsync low window, then go a random distance into it.
      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk);
         #1;
         if (hs0 == 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      check("hs_low_found", int'(found), 1);
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #2;
      check("pre_rst_hsync", int'(hs0), 0);
      btns = 1'b1;
      #1;
      check("async_hsync", int'(hs0), 1);
      check("async_vsync", int'(vs0), 1);
      check("async_led1",  int'(led1), 0);
      hold = $urandom_range(2, 6);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      btns = 1'b0;
      clear_edges();

      repeat (22000) @(posedge clk);
      @(negedge clk);
      check("re_hs_fall0", q_at(hs0_fall, 0), 2624);
      check("re_hs_fall1", q_at(hs0_fall, 1), 5824);
      check("re_vs_fall0", q_at(vs1_fall, 0), 19200);
      check("re_led_rise", q_at(led1_rise, 0), 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
